// File: rtl/mux_arb_nxw_pkg.sv
// ----------------------------------------------------------------------------
// mux_arb_nxw_pkg
// Shared definitions for the N-channel registered selector/arbiter:
//   MODE_FIXED / MODE_RR  - values of the Mode input
//   sel_width()           - clog2 with a floor of 1, sizes select/ID fields
// ----------------------------------------------------------------------------
package mux_arb_nxw_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Number of bits needed to encode n channel indices, never less than 1.
   function automatic int sel_width(input int n);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((32'sd1 << i) < n) begin
            w = i + 1;
         end else begin
            w = w;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/mux_arb_nxw_if.sv
// ----------------------------------------------------------------------------
// mux_arb_nxw_if
// Bundles the producer-side and consumer-side handshake/data signals of
// mux_arb_nxw.
//   Mode, S             - arbitration mode and fixed-mode channel select
//   A, Valid_in         - flattened channel data and per-channel valid
//   Ready_in            - per-channel ready (combinational from the block)
//   Y, Y_ch, Y_valid    - registered output data, source channel, valid
//   Y_ready             - consumer accept
// Modports: master = environment (producers + consumer), slave = the block.
// ----------------------------------------------------------------------------
interface mux_arb_nxw_if #(
   parameter int WIDTH = 32,
   parameter int N     = 4
);
   import mux_arb_nxw_pkg::*;

   localparam int SW = sel_width(N);

   logic                 Mode;
   logic [SW-1:0]        S;
   logic [N*WIDTH-1:0]   A;
   logic [N-1:0]         Valid_in;
   logic [N-1:0]         Ready_in;
   logic [WIDTH-1:0]     Y;
   logic [SW-1:0]        Y_ch;
   logic                 Y_valid;
   logic                 Y_ready;

   modport master (
      output Mode, S, A, Valid_in, Y_ready,
      input  Ready_in, Y, Y_ch, Y_valid
   );

   modport slave (
      input  Mode, S, A, Valid_in, Y_ready,
      output Ready_in, Y, Y_ch, Y_valid
   );

endinterface

// File: rtl/mux_arb_nxw_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Round-robin picker: finds the first set request scanning from ptr_i upward
// with wrap-around.
//   req_i    - request vector
//   ptr_i    - scan start index (must be < N)
//   grant_o  - one-hot grant
//   idx_o    - encoded index of the granted request
//   any_o    - at least one request was granted
// The request vector is concatenated with itself and rotated down by ptr_i,
// so a plain lowest-bit priority search on the rotated vector implements the
// wrap-around scan; the found offset is then mapped back by adding ptr_i mod N.
// ----------------------------------------------------------------------------
module rr_pick
   import mux_arb_nxw_pkg::*;
#(
   parameter int N  = 4,
   parameter int SW = sel_width(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [SW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [SW-1:0] idx_o,
   output logic          any_o
);

   logic [2*N-1:0] dbl_s;
   logic [N-1:0]   rot_s;
   logic [SW-1:0]  off_s;
   logic           found_s;
   logic [SW:0]    sum_s;

   // Rotate the doubled request vector so bit 0 corresponds to ptr_i.
   always_comb begin
      dbl_s = {req_i, req_i};
      rot_s = '0;
      for (int i = 0; i < N; i++) begin
         rot_s[i] = dbl_s[i + int'(ptr_i)];
      end
   end

   // Lowest set bit of the rotated vector is the offset from ptr_i.
   always_comb begin
      found_s = 1'b0;
      off_s   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot_s[k]) begin
            found_s = 1'b1;
            off_s   = SW'(k);
         end else begin
            found_s = found_s;
         end
      end
   end

   // Map the offset back to an absolute channel index and build the grant.
   always_comb begin
      sum_s = {1'b0, ptr_i} + {1'b0, off_s};
      if (sum_s >= (SW+1)'(N)) begin
         sum_s = sum_s - (SW+1)'(N);
      end else begin
         sum_s = sum_s;
      end
      idx_o = sum_s[SW-1:0];
      any_o = found_s;
      if (found_s) begin
         grant_o = N'(1'b1) << sum_s[SW-1:0];
      end else begin
         grant_o = '0;
      end
   end

endmodule

// File: rtl/mux_arb_nxw.sv
// ----------------------------------------------------------------------------
// mux_arb_nxw
// N-channel, WIDTH-bit selector with a registered output stage and
// valid/ready handshakes on both sides. Mode selects a fixed channel (S) or
// round-robin arbitration among valid channels.
//   Clk   - clock, rising edge
//   Clrn  - asynchronous active-low reset
//   bus   - mux_arb_nxw_if.slave: Mode, S, A, Valid_in, Ready_in,
//           Y, Y_ch, Y_valid, Y_ready
// Ready_in depends only on handshake/control state, never on A, so the data
// path has no combinational route to any output.
// ----------------------------------------------------------------------------
module mux_arb_nxw
   import mux_arb_nxw_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N     = 4
) (
   input  logic           Clk,
   input  logic           Clrn,
   mux_arb_nxw_if.slave   bus
);

   localparam int SW = sel_width(N);

   // Output register and round-robin pointer
   logic [WIDTH-1:0] y_q,    y_d;
   logic [SW-1:0]    ych_q,  ych_d;
   logic             yv_q,   yv_d;
   logic [SW-1:0]    ptr_q,  ptr_d;

   // Arbitration results
   logic [N-1:0]     fix_grant_s;
   logic             fix_any_s;
   logic [N-1:0]     rr_grant_s;
   logic [SW-1:0]    rr_idx_s;
   logic             rr_any_s;
   logic [N-1:0]     grant_s;
   logic [SW-1:0]    gidx_s;
   logic             any_s;
   logic             can_load_s;
   logic             xfer_s;
   logic [N-1:0]     ready_s;
   logic [WIDTH-1:0] sel_data_s;

   rr_pick #(
      .N  (N),
      .SW (SW)
   ) u_rr_pick (
      .req_i   (bus.Valid_in),
      .ptr_i   (ptr_q),
      .grant_o (rr_grant_s),
      .idx_o   (rr_idx_s),
      .any_o   (rr_any_s)
   );

   // Fixed-mode decode; an out-of-range S (non power-of-two N) grants nothing.
   always_comb begin
      fix_grant_s = '0;
      if ({1'b0, bus.S} < (SW+1)'(N)) begin
         fix_grant_s[bus.S] = bus.Valid_in[bus.S];
      end else begin
         fix_grant_s = '0;
      end
      fix_any_s = |fix_grant_s;
   end

   // Mode mux between fixed decode and round-robin picker.
   always_comb begin
      case (bus.Mode)
         MODE_FIXED: begin
            grant_s = fix_grant_s;
            gidx_s  = bus.S;
            any_s   = fix_any_s;
         end
         MODE_RR: begin
            grant_s = rr_grant_s;
            gidx_s  = rr_idx_s;
            any_s   = rr_any_s;
         end
         default: begin
            grant_s = '0;
            gidx_s  = '0;
            any_s   = 1'b0;
         end
      endcase
   end

   // Handshake: ready only to the granted channel, and never while in reset.
   always_comb begin
      can_load_s = !yv_q || bus.Y_ready;
      xfer_s     = can_load_s && any_s && Clrn;
      if (Clrn && can_load_s) begin
         ready_s = grant_s;
      end else begin
         ready_s = '0;
      end
   end

   // Granted channel's data slice; only meaningful when xfer_s is set.
   always_comb begin
      sel_data_s = bus.A[int'(gidx_s) * WIDTH +: WIDTH];
   end

   // Next-state: load on transfer, drain on accept without replacement.
   always_comb begin
      y_d   = y_q;
      ych_d = ych_q;
      yv_d  = yv_q;
      ptr_d = ptr_q;
      if (xfer_s) begin
         y_d   = sel_data_s;
         ych_d = gidx_s;
         yv_d  = 1'b1;
         if (bus.Mode == MODE_RR) begin
            if (gidx_s == SW'(N - 1)) begin
               ptr_d = '0;
            end else begin
               ptr_d = gidx_s + SW'(1);
            end
         end else begin
            ptr_d = ptr_q;
         end
      end else if (yv_q && bus.Y_ready) begin
         yv_d = 1'b0;
      end else begin
         yv_d = yv_q;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         y_q   <= '0;
         ych_q <= '0;
         yv_q  <= 1'b0;
         ptr_q <= '0;
      end else begin
         y_q   <= y_d;
         ych_q <= ych_d;
         yv_q  <= yv_d;
         ptr_q <= ptr_d;
      end
   end

   assign bus.Ready_in = ready_s;
   assign bus.Y        = y_q;
   assign bus.Y_ch     = ych_q;
   assign bus.Y_valid  = yv_q;

endmodule

// File: tb/tb_mux_arb_nxw.sv
// ----------------------------------------------------------------------------
// tb_mux_arb_nxw
// Self-checking bench for mux_arb_nxw with WIDTH=32, N=4: a table of
// per-cycle vectors with hand-computed expectations, plus directed
// sequences for reset, back-pressure and mid-operation reset.
// ----------------------------------------------------------------------------
module tb_mux_arb_nxw;

   localparam int WIDTH = 32;
   localparam int N     = 4;

   logic clk;
   logic clrn;
   int   checks;
   int   failures;

   mux_arb_nxw_if #(.WIDTH(WIDTH), .N(N)) bus_if ();

   mux_arb_nxw #(.WIDTH(WIDTH), .N(N)) dut (
      .Clk  (clk),
      .Clrn (clrn),
      .bus  (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        mode;
      logic [1:0]  s;
      logic [3:0]  valid;
      logic        yready;
      logic [3:0]  exp_ready;
      logic        exp_yv;
      logic [1:0]  exp_ych;
      logic [31:0] exp_y;
   } vec_t;

   vec_t tbl[17];

   localparam logic [31:0] D0 = 32'h1111_0000;
   localparam logic [31:0] D1 = 32'h2222_0001;
   localparam logic [31:0] D2 = 32'hDEAD_BEEF;
   localparam logic [31:0] D3 = 32'h4444_0003;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic mode, input logic [1:0] s, input logic [3:0] valid,
                        input logic yready);
      bus_if.Mode     = mode;
      bus_if.S        = s;
      bus_if.Valid_in = valid;
      bus_if.Y_ready  = yready;
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      bus_if.A = {D3, D2, D1, D0};
      drive(1'b0, 2'd0, 4'b1111, 1'b1);
      clrn = 1'b0;

      // ---------------- reset hold ----------------
      tick();
      tick();
      chk("rst_ready",  {28'd0, bus_if.Ready_in}, 32'd0);
      chk("rst_yvalid", {31'd0, bus_if.Y_valid},  32'd0);
      chk("rst_y",      bus_if.Y,                 32'd0);
      chk("rst_ych",    {30'd0, bus_if.Y_ch},     32'd0);
      @(negedge clk);
      clrn = 1'b1;
      #1;
      chk("rel_ready",  {28'd0, bus_if.Ready_in}, 32'h1);
      tick();
      chk("rel_yvalid", {31'd0, bus_if.Y_valid},  32'd1);
      chk("rel_y",      bus_if.Y,                 D0);
      chk("rel_ych",    {30'd0, bus_if.Y_ch},     32'd0);

      // ---------------- table ----------------
      //            mode  s     valid    yr    ready    yv    ych   y
      tbl[0]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, D2};
      tbl[1]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, D2};
      tbl[2]  = '{1'b0, 2'd1, 4'b0101, 1'b1, 4'b0000, 1'b0, 2'd2, D2};
      tbl[3]  = '{1'b0, 2'd3, 4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, D3};
      tbl[4]  = '{1'b0, 2'd0, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd3, D3};
      tbl[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, D0};
      tbl[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, D1};
      tbl[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, D2};
      tbl[8]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, D3};
      tbl[9]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, D0};
      tbl[10] = '{1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, D0};
      tbl[11] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, D1};
      tbl[12] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, D1};
      tbl[13] = '{1'b1, 2'd0, 4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, D0};
      tbl[14] = '{1'b1, 2'd0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, D2};
      tbl[15] = '{1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, D1};
      tbl[16] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, D2};

      for (int i = 0; i < 17; i++) begin
         drive(tbl[i].mode, tbl[i].s, tbl[i].valid, tbl[i].yready);
         #1;
         chk($sformatf("tbl%0d_ready", i), {28'd0, bus_if.Ready_in}, {28'd0, tbl[i].exp_ready});
         tick();
         chk($sformatf("tbl%0d_yvalid", i), {31'd0, bus_if.Y_valid}, {31'd0, tbl[i].exp_yv});
         chk($sformatf("tbl%0d_ych", i),    {30'd0, bus_if.Y_ch},    {30'd0, tbl[i].exp_ych});
         chk($sformatf("tbl%0d_y", i),      bus_if.Y,                tbl[i].exp_y);
      end

      // ---------------- back-pressure ----------------
      drive(1'b0, 2'd3, 4'b1000, 1'b1);
      tick();
      chk("bp_load_y", bus_if.Y, D3);
      drive(1'b0, 2'd3, 4'b1000, 1'b0);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("bp%0d_ready", c), {28'd0, bus_if.Ready_in}, 32'd0);
         tick();
         chk($sformatf("bp%0d_y", c),      bus_if.Y,                D3);
         chk($sformatf("bp%0d_yvalid", c), {31'd0, bus_if.Y_valid}, 32'd1);
      end
      drive(1'b0, 2'd1, 4'b0010, 1'b1);
      #1;
      chk("bp_rel_ready", {28'd0, bus_if.Ready_in}, 32'h2);
      tick();
      chk("bp_rel_y",      bus_if.Y,                D1);
      chk("bp_rel_ych",    {30'd0, bus_if.Y_ch},    32'd1);
      chk("bp_rel_yvalid", {31'd0, bus_if.Y_valid}, 32'd1);

      // ---------------- mid-operation reset ----------------
      // ptr is 3 here; channel 1 moves it to 2 and leaves Y_ch = 1.
      drive(1'b1, 2'd0, 4'b0010, 1'b1);
      tick();
      chk("mr_pre_ych", {30'd0, bus_if.Y_ch}, 32'd1);
      drive(1'b1, 2'd0, 4'b0000, 1'b0);
      #2;
      clrn = 1'b0;
      #1;
      chk("mr_yvalid", {31'd0, bus_if.Y_valid}, 32'd0);
      chk("mr_y",      bus_if.Y,                32'd0);
      chk("mr_ych",    {30'd0, bus_if.Y_ch},    32'd0);
      drive(1'b1, 2'd0, 4'b1111, 1'b1);
      #1;
      chk("mr_ready", {28'd0, bus_if.Ready_in}, 32'd0);
      @(negedge clk);
      clrn = 1'b1;
      #1;
      chk("mr_rel_ready", {28'd0, bus_if.Ready_in}, 32'h1);
      tick();
      chk("mr_rel_ych", {30'd0, bus_if.Y_ch}, 32'd0);
      chk("mr_rel_y",   bus_if.Y,             D0);
      #1;
      chk("mr_next_ready", {28'd0, bus_if.Ready_in}, 32'h2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mux_arb_nxw.md
# mux_arb_nxw

Parametrised N-channel, WIDTH-bit selector with a registered output and valid/ready handshakes. It is the successor to the combinational 2:1 32-bit selector. Two modes are supported: a fixed select driven by `S`, and round-robin arbitration among valid channels. It sits between multiple datapath producers (writeback sources, bus masters) and a single consumer, and adds one pipeline stage.

## Interface
Parameters:
- `WIDTH`, 32, data width per channel
- `N`, 4, channel count; 2 ≤ N ≤ 16
- `SW`, derived as clog2(N) (minimum 1), width of the select and channel-ID fields; localparam, not overridable

Ports:
- `Clk`  in  1  clock; all state updates on the rising edge
- `Clrn`  in  1  reset; asynchronous, active-low
- `Mode`  in  1  0 = fixed select (MODE_FIXED), 1 = round-robin (MODE_RR)
- `S`  in  SW  channel select, used in fixed mode only
- `A`  in  N*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH]
- `Valid_in`  in  N  per-channel valid
- `Ready_in`  out  N  per-channel ready (combinational)
- `Y`  out  WIDTH  registered output data
- `Y_ch`  out  SW  index of the channel that supplied `Y`
- `Y_valid`  out  1  output register holds data
- `Y_ready`  in  1  consumer accepts `Y`

## Operation
- **Output register load:**
  - `can_load = !Y_valid || Y_ready`.
  - A transfer on channel i occurs when `Valid_in[i] && Ready_in[i]`.
  - `Ready_in[i] = can_load && grant[i]`.
  - At most one bit of `grant` is set.
- **Fixed mode:**
  - `grant[S] = Valid_in[S]`.
  - If `S` ≥ N (N not a power of two), there is no grant.
  - The round-robin pointer is held.
- **Round-robin mode:**
  - The granted channel is the first valid channel found scanning `ptr`, `ptr+1`, … mod N.
  - On a transfer, `ptr` ← (granted index + 1) mod N.
  - With no transfer, `ptr` holds.
  - Wrap-around: after channel N-1 is granted, `ptr` = 0.
- **On transfer:** `Y` ← channel data, `Y_ch` ← index, `Y_valid` ← 1.
- **Drain:** if `Y_valid && Y_ready` and there is no new transfer, `Y_valid` ← 0. `Y` and `Y_ch` hold their last values.
- **Simultaneous drain and load:** the register is replaced in the same cycle, with no bubble.
- **Mode or S change:** takes effect combinationally in the same cycle. No data is lost, because ungranted channels see ready = 0 and must hold.
- **Reset (asserted at any time, including mid-transfer):**
  - `Y` = 0, `Y_ch` = 0, `Y_valid` = 0, `ptr` = 0.
  - `Ready_in` = 0 while `Clrn` is low.
  - In-flight output data is discarded.

## Timing
- Latency: an input accepted at edge k appears with `Y_valid` = 1 after edge k.
- Throughput: one transfer per cycle while `Y_ready` = 1.
- `Ready_in` is combinational from `Y_valid`, `Y_ready`, `Valid_in`, `Mode`, `S` and `ptr`. There is no combinational path from `A` to any output.
- Producers must hold `Valid_in` and data stable until accepted. The block itself never drops `Y_valid` without `Y_ready`.
- Reset release is synchronised externally. The first transfer can occur on the first edge after `Clrn` rises.

## Structure
- The shared defines/package holds:
  - MODE_FIXED = 1'b0 and MODE_RR = 1'b1
  - the clog2 function used for `SW`
- One sub-module: `rr_pick`.
  - Parametrised on N.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant, encoded index, and an any-grant flag.
  - Implemented as a double-width rotate-and-priority scheme.
- The output register, pointer, fixed-mode decode and handshake logic live in `mux_arb_nxw`.

## Test plan
- **Reset:** hold `Clrn` = 0 with all `Valid_in` = 1. Require `Y_valid` = 0, `Y` = 0, `Ready_in` = 0. After release, the first accept occurs on the next edge.
- **Fixed mode, N=4:** `S` = 2, `Valid_in` = 4'b1111, `A[2]` = 32'hDEADBEEF, `Y_ready` = 1. Require `Ready_in` = 4'b0100, `Y` = DEADBEEF and `Y_ch` = 2 one cycle later. No other channel is accepted.
- **Round-robin fairness:** all four channels valid continuously, `Y_ready` = 1. Require `Y_ch` sequence 0,1,2,3,0,1… at one per cycle, showing the wrap-around.
- **Back-pressure:** `Y_valid` = 1 and `Y_ready` = 0 for 3 cycles. Require `Ready_in` = 0 and `Y` stable. Then pulse `Y_ready` = 1 with channel 1 valid: `Y` is replaced in the same cycle, no bubble.
- **Sparse requests:** round-robin mode, `ptr` = 3, only channel 1 valid. Require grant to channel 1, then `ptr` = 2.
- **Mid-operation reset:** assert `Clrn` = 0 while `Y_valid` = 1, asynchronously between edges. Require `Y_valid`, `Y` and `Y_ch` to go to 0 immediately and `ptr` to restart at 0.
